// File: rtl/max_pooling_layer.sv
// Streaming 2x2 stride-2 signed max-pooling stage for the conv output pixel stream.
// Buffers one row of horizontal maxima so one pixel per cycle is accepted with no stall.
module max_pooling_layer #(
    parameter int unsigned D_WIDTH      = 16,
    parameter int unsigned CHANNELS     = 5,
    parameter int unsigned IMAGE_WIDTH  = 60,
    parameter int unsigned IMAGE_HEIGHT = 28
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_en,
    input  logic [CHANNELS*D_WIDTH-1:0]  input_data,
    input  logic                         input_valid,
    output logic [CHANNELS*D_WIDTH-1:0]  output_data,
    output logic                         valid
);

    localparam int unsigned PixW     = CHANNELS * D_WIDTH;
    localparam int unsigned BufDepth = (IMAGE_WIDTH / 2 > 0) ? IMAGE_WIDTH / 2 : 1;
    localparam int unsigned ColW     = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int unsigned RowW     = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int unsigned IdxW     = (BufDepth > 1) ? $clog2(BufDepth) : 1;

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [PixW-1:0] pair_q, pair_d;
    logic [PixW-1:0] out_q, out_d;
    logic            valid_q, valid_d;

    logic [PixW-1:0] line_buf [BufDepth];
    logic [IdxW-1:0] buf_idx;
    logic [PixW-1:0] hmax;
    logic [PixW-1:0] pooled;
    logic            buf_we;

    function automatic logic [D_WIDTH-1:0] smax(input logic [D_WIDTH-1:0] a,
                                                input logic [D_WIDTH-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    // Odd columns only reach the buffer, so col>>1 always lands inside it.
    assign buf_idx = IdxW'(col_q >> 1);

    always_comb begin
        hmax   = '0;
        pooled = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hmax[c*D_WIDTH +: D_WIDTH]   = smax(pair_q[c*D_WIDTH +: D_WIDTH],
                                                input_data[c*D_WIDTH +: D_WIDTH]);
            pooled[c*D_WIDTH +: D_WIDTH] = smax(line_buf[buf_idx][c*D_WIDTH +: D_WIDTH],
                                                hmax[c*D_WIDTH +: D_WIDTH]);
        end
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        pair_d  = pair_q;
        out_d   = out_q;
        valid_d = valid_q;
        buf_we  = 1'b0;
        if (clk_en) begin
            valid_d = 1'b0;
            if (input_valid) begin
                if (col_q == ColW'(IMAGE_WIDTH - 1)) begin
                    col_d = '0;
                    row_d = (row_q == RowW'(IMAGE_HEIGHT - 1)) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                if (!col_q[0]) begin
                    pair_d = input_data;
                end else if (!row_q[0]) begin
                    buf_we = 1'b1;
                end else begin
                    out_d   = pooled;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    // Not reset: each entry is written in an even row before its odd-row read.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[buf_idx] <= hmax;
        end
    end

    assign output_data = out_q;
    assign valid       = valid_q;

endmodule
